// File: rtl/iram_loader.sv
// Instruction RAM with registered fetch read and a byte-stream loader that
// packs little-endian bytes into words at auto-incrementing addresses.
module iram_loader #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_RdEn,
  input  logic                       i_OZero,
  input  logic [$clog2(DEPTH)-1:0]   i_Addr,
  output logic [WIDTH-1:0]           o_Inst,
  input  logic                       i_LdStart,
  input  logic [$clog2(DEPTH)-1:0]   i_LdBase,
  input  logic                       i_LdValid,
  output logic                       o_LdReady,
  input  logic [7:0]                 i_LdByte,
  input  logic                       i_LdLast,
  output logic                       o_LdBusy,
  output logic                       o_LdDone,
  output logic                       o_LdErr,
  output logic [$clog2(DEPTH+1)-1:0] o_LdCount
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int BYTES  = WIDTH / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(BYTES - 1);
  localparam logic [AW-1:0]     PTR_MAX  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [AW-1:0]      ptr_reg, ptr_next;
  logic [LANE_W-1:0]  lane_reg, lane_next;
  logic [WIDTH-1:0]   asm_reg, asm_next;
  logic [WIDTH-1:0]   asm_fill;
  logic               last_reg, last_next;
  logic [CW-1:0]      count_reg, count_next;
  logic               err_reg, err_next;
  logic [WIDTH-1:0]   rd_reg;
  logic               byte_accept;
  logic               wr_en;

  // Contents are zero at configuration and deliberately survive reset.
  logic [WIDTH-1:0] ram_reg [DEPTH] = '{default: '0};

  always_ff @(posedge i_Clk) begin
    if (wr_en) begin
      ram_reg[ptr_reg] <= asm_reg;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rd_reg <= '0;
    end else if (i_RdEn) begin
      rd_reg <= ram_reg[i_Addr];
    end
  end

  assign o_Inst = i_OZero ? '0 : rd_reg;

  assign byte_accept = (state_reg == ST_COLLECT) && i_LdValid;

  // Only the lane selected by the lane counter takes the incoming byte.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      assign asm_fill[gi*8 +: 8] = (lane_reg == LANE_W'(gi)) ? i_LdByte : asm_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      lane_reg  <= '0;
      asm_reg   <= '0;
      last_reg  <= 1'b0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      lane_reg  <= lane_next;
      asm_reg   <= asm_next;
      last_reg  <= last_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    lane_next  = lane_reg;
    asm_next   = asm_reg;
    last_next  = last_reg;
    count_next = count_reg;
    err_next   = err_reg;
    wr_en      = 1'b0;
    o_LdReady  = 1'b0;
    o_LdDone   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_LdStart) begin
          ptr_next   = i_LdBase;
          lane_next  = '0;
          asm_next   = '0;
          last_next  = 1'b0;
          count_next = '0;
          err_next   = 1'b0;
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        o_LdReady = 1'b1;
        if (byte_accept) begin
          asm_next  = asm_fill;
          lane_next = lane_reg + LANE_W'(1);
          if ((lane_reg == LANE_MAX) || i_LdLast) begin
            last_next  = i_LdLast;
            state_next = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        wr_en      = 1'b1;
        count_next = count_reg + CW'(1);
        asm_next   = '0;
        lane_next  = '0;
        if (last_reg) begin
          state_next = ST_DONE;
        end else if (ptr_reg == PTR_MAX) begin
          // Pointer never wraps: running off the top ends the session.
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          ptr_next   = ptr_reg + AW'(1);
          state_next = ST_COLLECT;
        end
      end
      ST_DONE: begin
        o_LdDone   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_LdBusy  = (state_reg == ST_COLLECT) || (state_reg == ST_WRITE);
  assign o_LdErr   = err_reg;
  assign o_LdCount = count_reg;

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: load sessions, overrun, reset mid-session,
// read-before-write, then a table of fetch vectors over the loaded image.
module tb_iram_loader;

  localparam int DEPTH = 32;
  localparam int WIDTH = 32;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_RdEn = 1'b0;
  logic        i_OZero = 1'b0;
  logic [4:0]  i_Addr = '0;
  logic [31:0] o_Inst;
  logic        i_LdStart = 1'b0;
  logic [4:0]  i_LdBase = '0;
  logic        i_LdValid = 1'b0;
  logic        o_LdReady;
  logic [7:0]  i_LdByte = '0;
  logic        i_LdLast = 1'b0;
  logic        o_LdBusy;
  logic        o_LdDone;
  logic        o_LdErr;
  logic [5:0]  o_LdCount;

  iram_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_RdEn(i_RdEn), .i_OZero(i_OZero),
    .i_Addr(i_Addr), .o_Inst(o_Inst), .i_LdStart(i_LdStart),
    .i_LdBase(i_LdBase), .i_LdValid(i_LdValid), .o_LdReady(o_LdReady),
    .i_LdByte(i_LdByte), .i_LdLast(i_LdLast), .o_LdBusy(o_LdBusy),
    .o_LdDone(o_LdDone), .o_LdErr(o_LdErr), .o_LdCount(o_LdCount)
  );

  always #5 i_Clk = ~i_Clk;

  int n_total = 0;
  int n_pass  = 0;
  int done_cnt  = 0;
  int write_cyc = 0;
  int busy_cyc  = 0;

  // Per-cycle observation of the handshake outputs, sampled mid-cycle.
  always @(negedge i_Clk) begin
    if (o_LdDone) done_cnt++;
    if (o_LdBusy && !o_LdReady) write_cyc++;
    if (o_LdBusy) busy_cyc++;
  end

  typedef struct {
    logic [4:0]  addr;
    logic        ozero;
    logic [31:0] exp;
  } fetch_vec_t;

  fetch_vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
      $display("check %-16s got %08h", name, act);
    end else begin
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic settle();
    @(negedge i_Clk);
    #1;
  endtask

  task automatic start_load(input logic [4:0] base);
    i_LdStart = 1'b1;
    i_LdBase  = base;
    @(negedge i_Clk);
    i_LdStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    i_LdValid = 1'b1;
    i_LdByte  = b;
    i_LdLast  = last;
    while (!o_LdReady && n < 20) begin
      @(negedge i_Clk);
      n++;
    end
    if (!o_LdReady) begin
      n_total++;
      $display("FAIL send_byte_timeout: got ready=0 expected ready=1 within 20 cycles");
    end
    @(negedge i_Clk);
    i_LdValid = 1'b0;
    i_LdLast  = 1'b0;
  endtask

  task automatic fetch(input string name, input logic [4:0] addr, input logic oz, input logic [31:0] exp);
    i_Addr  = addr;
    i_RdEn  = 1'b1;
    i_OZero = 1'b0;
    @(negedge i_Clk);
    i_RdEn  = 1'b0;
    i_OZero = oz;
    #1;
    check(name, o_Inst, exp);
    i_OZero = 1'b0;
  endtask

  initial begin
    int d0, w0, b0, ready_seen;

    vecs[0] = '{5'd0,  1'b0, 32'h0020_0293};
    vecs[1] = '{5'd0,  1'b1, 32'h0000_0000};
    vecs[2] = '{5'd5,  1'b0, 32'h1413_1211};
    vecs[3] = '{5'd6,  1'b0, 32'h2423_2221};
    vecs[4] = '{5'd7,  1'b0, 32'h0000_1A19};
    vecs[5] = '{5'd31, 1'b0, 32'h3433_3231};
    vecs[6] = '{5'd10, 1'b0, 32'hDDCC_BBAA};
    vecs[7] = '{5'd1,  1'b0, 32'h0000_0000};
    vecs[8] = '{5'd30, 1'b0, 32'h0000_0000};
    vecs[9] = '{5'd31, 1'b1, 32'h0000_0000};

    repeat (3) @(negedge i_Clk);
    i_Rst = 1'b0;
    #1;
    check("rst_inst",  o_Inst, 32'h0);
    check("rst_ready", {31'b0, o_LdReady}, 32'h0);
    check("rst_busy",  {31'b0, o_LdBusy}, 32'h0);
    check("rst_done",  {31'b0, o_LdDone}, 32'h0);
    check("rst_err",   {31'b0, o_LdErr}, 32'h0);
    check("rst_count", {26'b0, o_LdCount}, 32'h0);
    for (int a = 0; a < 4; a++) fetch($sformatf("init_fetch%0d", a), 5'(a), 1'b0, 32'h0);

    // Single word at base 0.
    d0 = done_cnt;
    start_load(5'd0);
    send_byte(8'h93, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b1);
    repeat (3) @(negedge i_Clk);
    #1;
    check("w1_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("w1_count", {26'b0, o_LdCount}, 32'd1);
    fetch("w1_fetch0", 5'd0, 1'b0, 32'h0020_0293);

    // Ten bytes streamed back-to-back from base 5; last word partial.
    d0 = done_cnt; w0 = write_cyc; b0 = busy_cyc;
    start_load(5'd5);
    for (int k = 0; k < 10; k++) send_byte(8'h11 + 8'(k), k == 9);
    repeat (3) @(negedge i_Clk);
    #1;
    check("s3_count", {26'b0, o_LdCount}, 32'd3);
    check("s3_done_pulses", 32'(done_cnt - d0), 32'd1);
    check("s3_write_cycles", 32'(write_cyc - w0), 32'd3);
    check("s3_busy_cycles", 32'(busy_cyc - b0), 32'd13);
    fetch("s3_fetch7", 5'd7, 1'b0, 32'h0000_1A19);

    // Overrun from the top word: one write, then error, bytes ignored.
    d0 = done_cnt;
    start_load(5'd31);
    for (int k = 0; k < 4; k++) send_byte(8'h31 + 8'(k), 1'b0);
    ready_seen = 0;
    for (int k = 0; k < 4; k++) begin
      i_LdValid = 1'b1;
      i_LdByte  = 8'h41 + 8'(k);
      #1;
      if (o_LdReady) ready_seen++;
      @(negedge i_Clk);
    end
    i_LdValid = 1'b0;
    #1;
    check("ov_ready_seen", 32'(ready_seen), 32'd0);
    check("ov_err", {31'b0, o_LdErr}, 32'd1);
    check("ov_busy", {31'b0, o_LdBusy}, 32'd0);
    check("ov_count", {26'b0, o_LdCount}, 32'd1);
    settle();
    check("ov_err_sticky", {31'b0, o_LdErr}, 32'd1);
    check("ov_no_done", 32'(done_cnt - d0), 32'd0);

    // A fresh session clears the error flag.
    start_load(5'd10);
    #1;
    check("new_err_clear", {31'b0, o_LdErr}, 32'd0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    repeat (3) @(negedge i_Clk);

    // Reset with half a word collected at address 5.
    start_load(5'd5);
    send_byte(8'hEE, 1'b0);
    send_byte(8'hFF, 1'b0);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    #1;
    check("mr_busy",  {31'b0, o_LdBusy}, 32'h0);
    check("mr_ready", {31'b0, o_LdReady}, 32'h0);
    check("mr_count", {26'b0, o_LdCount}, 32'h0);
    check("mr_inst",  o_Inst, 32'h0);
    fetch("mr_word5", 5'd5, 1'b0, 32'h1413_1211);

    // Fetch of the address being written in the same cycle returns old data.
    start_load(5'd6);
    send_byte(8'h21, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h23, 1'b0);
    send_byte(8'h24, 1'b1);
    i_Addr = 5'd6;
    i_RdEn = 1'b1;
    settle();
    check("rbw_old", o_Inst, 32'h1817_1615);
    settle();
    check("rbw_new", o_Inst, 32'h2423_2221);
    i_RdEn = 1'b0;
    repeat (3) @(negedge i_Clk);

    for (int i = 0; i < 10; i++)
      fetch($sformatf("vec%0d_a%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].ozero, vecs[i].exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
